// File: rtl/byte_exec_pkg.sv
// Shared definitions for the byte-serial execution unit: op encodings,
// FSM states, phase count and small op-classification helpers.
package byte_exec_pkg;

   localparam int NPHASE = 4;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_XOR   = 3'd4,
      OP_SLT   = 3'd5,
      OP_SLTU  = 3'd6,
      OP_PASSB = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_CMPWR = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   function automatic logic is_cmp(input op_e op);
      return (op == OP_SLT) || (op == OP_SLTU);
   endfunction

   // Ops that run the adder as a subtractor (carry-in 1 at phase 0).
   function automatic logic is_sub(input op_e op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   endfunction

endpackage

// File: rtl/byte_serial_exec_if.sv
// Request handshake plus byte-wide register-file port of byte_serial_exec.
interface byte_serial_exec_if;
   logic        start;
   logic [2:0]  op;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [3:0]  rd;
   logic [31:0] imm;
   logic        use_imm;
   logic        busy;
   logic        done;
   logic [1:0]  mux_phase;
   logic [3:0]  rf_rs1;
   logic [3:0]  rf_rs2;
   logic [3:0]  rf_rd;
   logic [7:0]  rs1_dat;
   logic [7:0]  rs2_dat;
   logic [7:0]  rd_dat;

   modport master (
      output start, op, rs1, rs2, rd, imm, use_imm, rs1_dat, rs2_dat,
      input  busy, done, mux_phase, rf_rs1, rf_rs2, rf_rd, rd_dat
   );

   modport slave (
      input  start, op, rs1, rs2, rd, imm, use_imm, rs1_dat, rs2_dat,
      output busy, done, mux_phase, rf_rs1, rf_rs2, rf_rd, rd_dat
   );
endinterface

// File: rtl/byte_alu_slice.sv
// Combinational 8-bit ALU slice; carry chains across phases through the caller.
module byte_alu_slice
   import byte_exec_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   input  op_e        op,
   output logic [7:0] res,
   output logic       cout
);

   logic [8:0] sum;

   // Byte operation with 9-bit result so the adder exposes its carry.
   always_comb begin
      sum = 9'd0;
      case (op)
         OP_ADD:                  sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
         OP_SUB, OP_SLT, OP_SLTU: sum = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
         OP_AND:                  sum = {1'b0, a & b};
         OP_OR:                   sum = {1'b0, a | b};
         OP_XOR:                  sum = {1'b0, a ^ b};
         OP_PASSB:                sum = {1'b0, b};
         default:                 sum = 9'd0;
      endcase
   end

   assign res  = sum[7:0];
   assign cout = sum[8];

endmodule

// File: rtl/byte_serial_exec.sv
// Executes one 32-bit register-register/immediate op a byte per cycle against
// an external byte-wide register file; compares take a second write pass.
module byte_serial_exec
   import byte_exec_pkg::*;
#(
   parameter int NPHASE = byte_exec_pkg::NPHASE
)(
   input  logic               clk,
   input  logic               rst,
   byte_serial_exec_if.slave  bus
);

   localparam logic [1:0] LAST_PHASE = 2'(NPHASE - 1);

   state_e      state;
   logic [1:0]  phase;
   logic        carry;
   logic        lt;
   op_e         op_r;
   logic [3:0]  rd_r;
   logic [31:0] imm_r;
   logic        use_imm_r;
   logic        busy_r;
   logic        done_r;
   logic [3:0]  rf_rs1_r;
   logic [3:0]  rf_rs2_r;
   logic [3:0]  rf_rd_r;

   logic [7:0]  b_byte;
   logic        cin;
   logic [7:0]  alu_res;
   logic        alu_cout;
   logic        lt_next;
   logic [7:0]  rd_dat_s;

   assign b_byte = use_imm_r ? imm_r[{phase, 3'b000} +: 8] : bus.rs2_dat;
   assign cin    = (phase == 2'd0) ? is_sub(op_r) : carry;

   byte_alu_slice u_alu (
      .a    (bus.rs1_dat),
      .b    (b_byte),
      .cin  (cin),
      .op   (op_r),
      .res  (alu_res),
      .cout (alu_cout)
   );

   // Signed compare falls back to the difference sign only when operand signs agree.
   always_comb begin
      if (op_r == OP_SLTU) begin
         lt_next = ~alu_cout;
      end else if (bus.rs1_dat[7] ^ b_byte[7]) begin
         lt_next = bus.rs1_dat[7];
      end else begin
         lt_next = alu_res[7];
      end
   end

   // Write byte: ALU result while executing, the compare flag in pass two.
   always_comb begin
      rd_dat_s = 8'd0;
      case (state)
         S_EXEC:  rd_dat_s = alu_res;
         S_CMPWR: rd_dat_s = (phase == 2'd0) ? {7'd0, lt} : 8'd0;
         default: rd_dat_s = 8'd0;
      endcase
   end

   // Sequencer: accept, byte phases, optional compare write-back, done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         phase     <= 2'd0;
         carry     <= 1'b0;
         lt        <= 1'b0;
         op_r      <= OP_ADD;
         rd_r      <= 4'd0;
         imm_r     <= 32'd0;
         use_imm_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         rf_rs1_r  <= 4'd0;
         rf_rs2_r  <= 4'd0;
         rf_rd_r   <= 4'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done_r   <= 1'b0;
               phase    <= 2'd0;
               if (bus.start) begin
                  state     <= S_EXEC;
                  busy_r    <= 1'b1;
                  carry     <= 1'b0;
                  op_r      <= op_e'(bus.op);
                  rd_r      <= bus.rd;
                  imm_r     <= bus.imm;
                  use_imm_r <= bus.use_imm;
                  rf_rs1_r  <= bus.rs1;
                  rf_rs2_r  <= bus.rs2;
                  // Compare pass one discards its difference bytes into x0.
                  rf_rd_r   <= is_cmp(op_e'(bus.op)) ? 4'd0 : bus.rd;
               end else begin
                  state    <= S_IDLE;
                  busy_r   <= 1'b0;
                  rf_rs1_r <= 4'd0;
                  rf_rs2_r <= 4'd0;
                  rf_rd_r  <= 4'd0;
               end
            end
            S_EXEC: begin
               carry <= alu_cout;
               phase <= phase + 2'd1;
               if (phase == LAST_PHASE) begin
                  if (is_cmp(op_r)) begin
                     state   <= S_CMPWR;
                     lt      <= lt_next;
                     rf_rd_r <= rd_r;
                  end else begin
                     state    <= S_DONE;
                     busy_r   <= 1'b0;
                     done_r   <= 1'b1;
                     rf_rs1_r <= 4'd0;
                     rf_rs2_r <= 4'd0;
                     rf_rd_r  <= 4'd0;
                  end
               end else begin
                  state <= S_EXEC;
               end
            end
            S_CMPWR: begin
               phase <= phase + 2'd1;
               if (phase == LAST_PHASE) begin
                  state    <= S_DONE;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  rf_rs1_r <= 4'd0;
                  rf_rs2_r <= 4'd0;
                  rf_rd_r  <= 4'd0;
               end else begin
                  state <= S_CMPWR;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               phase  <= 2'd0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.mux_phase = phase;
   assign bus.rf_rs1    = rf_rs1_r;
   assign bus.rf_rs2    = rf_rs2_r;
   assign bus.rf_rd     = rf_rd_r;
   assign bus.rd_dat    = rd_dat_s;

endmodule

// File: tb/tb_byte_serial_exec.sv
// Bench for byte_serial_exec: byte-wide register file model, vector table
// with a result scoreboard, and hand sequences for back-to-back and reset.
module tb_byte_serial_exec;
   import byte_exec_pkg::*;

   logic clk;
   logic rst;
   byte_serial_exec_if bus();

   byte_serial_exec dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: posedge byte write (x0 absorbed), negedge byte read.
   logic [31:0] rf [16] = '{default: 32'd0};
   logic        ld_en = 1'b0;
   logic [3:0]  ld_idx = 4'd0;
   logic [31:0] ld_val = 32'd0;
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (ld_en) begin
         rf[ld_idx] <= ld_val;
         wr_cnt     <= 0;
      end else if (bus.rf_rd != 4'd0) begin
         rf[bus.rf_rd][{bus.mux_phase, 3'b000} +: 8] <= bus.rd_dat;
         wr_cnt <= wr_cnt + 1;
      end
   end

   always @(negedge clk) begin
      bus.rs1_dat = rf[bus.rf_rs1][{bus.mux_phase, 3'b000} +: 8];
      bus.rs2_dat = rf[bus.rf_rs2][{bus.mux_phase, 3'b000} +: 8];
   end

   typedef struct {
      op_e         op;
      logic [3:0]  rd;
      logic        use_imm;
      logic [31:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          cyc;
   } vec_t;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] val;
      int          cyc;
   } sb_t;

   vec_t vecs [15];
   sb_t  sbq [$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input logic [3:0] idx, input logic [31:0] val);
      ld_en  = 1'b1;
      ld_idx = idx;
      ld_val = val;
      @(negedge clk);
      ld_en  = 1'b0;
   endtask

   task automatic wait_done(inout int cyc);
      while (bus.done !== 1'b1 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int  cyc;
      sb_t e;
      load(4'd1, v.a);
      load(4'd2, v.b);
      bus.start   = 1'b1;
      bus.op      = v.op;
      bus.rs1     = 4'd1;
      bus.rs2     = 4'd2;
      bus.rd      = v.rd;
      bus.use_imm = v.use_imm;
      bus.imm     = v.imm;
      sbq.push_back('{rd: v.rd, val: v.exp, cyc: v.cyc});
      @(negedge clk);
      // Scramble every request field while the op is in flight.
      bus.start   = 1'b0;
      bus.op      = ~v.op;
      bus.rs1     = 4'd2;
      bus.rs2     = 4'd1;
      bus.rd      = ~v.rd;
      bus.use_imm = ~v.use_imm;
      bus.imm     = ~v.imm;
      chk($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd1);
      cyc = 1;
      wait_done(cyc);
      e = sbq.pop_front();
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(e.cyc));
      chk($sformatf("v%0d_result", i), rf[e.rd], e.val);
      chk($sformatf("v%0d_writes", i), 32'(wr_cnt), (v.rd == 4'd0) ? 32'd0 : 32'd4);
      chk($sformatf("v%0d_busy_in_done", i), {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  cyc;
      logic saw_done;
      vecs[0]  = '{OP_ADD,   4'd3,  1'b0, 32'd0,         32'h000000FF, 32'h00000001, 32'h00000100, 5};
      vecs[1]  = '{OP_SUB,   4'd4,  1'b1, 32'h00000001,  32'h00000000, 32'h00000055, 32'hFFFFFFFF, 5};
      vecs[2]  = '{OP_SLT,   4'd5,  1'b0, 32'd0,         32'hFFFFFFFF, 32'h00000001, 32'h00000001, 9};
      vecs[3]  = '{OP_SLTU,  4'd6,  1'b0, 32'd0,         32'hFFFFFFFF, 32'h00000001, 32'h00000000, 9};
      vecs[4]  = '{OP_AND,   4'd8,  1'b0, 32'd0,         32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 5};
      vecs[5]  = '{OP_OR,    4'd9,  1'b0, 32'd0,         32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 5};
      vecs[6]  = '{OP_XOR,   4'd10, 1'b0, 32'd0,         32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 5};
      vecs[7]  = '{OP_PASSB, 4'd11, 1'b1, 32'hDEADBEEF,  32'h11111111, 32'h22222222, 32'hDEADBEEF, 5};
      vecs[8]  = '{OP_ADD,   4'd12, 1'b0, 32'd0,         32'hFFFFFFFF, 32'h00000002, 32'h00000001, 5};
      vecs[9]  = '{OP_SLT,   4'd13, 1'b0, 32'd0,         32'h7FFFFFFF, 32'h80000000, 32'h00000000, 9};
      vecs[10] = '{OP_SLTU,  4'd14, 1'b0, 32'd0,         32'h7FFFFFFF, 32'h80000000, 32'h00000001, 9};
      vecs[11] = '{OP_SUB,   4'd15, 1'b0, 32'd0,         32'h12345678, 32'h02345679, 32'h0FFFFFFF, 5};
      vecs[12] = '{OP_PASSB, 4'd0,  1'b1, 32'h12345678,  32'h00000000, 32'h00000000, 32'h00000000, 5};
      vecs[13] = '{OP_SLT,   4'd7,  1'b0, 32'd0,         32'h00000005, 32'h00000005, 32'h00000000, 9};
      vecs[14] = '{OP_SLT,   4'd6,  1'b0, 32'd0,         32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 9};

      rst = 1'b1;
      bus.start = 1'b1;
      bus.op = 3'd0; bus.rs1 = 4'd1; bus.rs2 = 4'd2; bus.rd = 4'd3;
      bus.imm = 32'd0; bus.use_imm = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_in_reset_busy", {31'd0, bus.busy}, 32'd0);
      bus.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_phase", {30'd0, bus.mux_phase}, 32'd0);
      chk("reset_rf_addrs", {20'd0, bus.rf_rs1, bus.rf_rs2, bus.rf_rd}, 32'd0);
      chk("reset_rd_dat", {24'd0, bus.rd_dat}, 32'd0);

      for (int i = 0; i < 15; i++) begin
         run_vec(i, vecs[i]);
      end
      chk("x0_zero", rf[0], 32'd0);

      // Start held high through an ADD: the next op is taken only in DONE.
      load(4'd1, 32'h00000010);
      load(4'd2, 32'h00000020);
      bus.start = 1'b1; bus.op = OP_ADD; bus.rs1 = 4'd1; bus.rs2 = 4'd2;
      bus.rd = 4'd3; bus.use_imm = 1'b0; bus.imm = 32'd0;
      @(negedge clk);
      bus.op = OP_XOR; bus.rs1 = 4'd2; bus.rs2 = 4'd1; bus.rd = 4'd4;
      bus.use_imm = 1'b1; bus.imm = 32'h0000FF00;
      cyc = 1;
      wait_done(cyc);
      chk("hold_first_cycle", 32'(cyc), 32'd5);
      chk("hold_first_result", rf[3], 32'h00000030);
      chk("hold_busy_in_done", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("hold_second_accepted", {31'd0, bus.busy}, 32'd1);
      chk("hold_done_width", {31'd0, bus.done}, 32'd0);
      cyc = 1;
      wait_done(cyc);
      chk("hold_second_cycle", 32'(cyc), 32'd5);
      chk("hold_second_result", rf[4], 32'h0000FF20);
      @(negedge clk);

      // Reset lands on the edge that would start phase 2 of an XOR into x7.
      load(4'd7, 32'hAAAAAAAA);
      load(4'd1, 32'h0F0F0F0F);
      load(4'd2, 32'h11111111);
      bus.start = 1'b1; bus.op = OP_XOR; bus.rs1 = 4'd1; bus.rs2 = 4'd2;
      bus.rd = 4'd7; bus.use_imm = 1'b0; bus.imm = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_rf_rd", {28'd0, bus.rf_rd}, 32'd0);
      chk("abort_x7", rf[7], 32'hAAAA1E1E);
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      chk("abort_no_done", {31'd0, saw_done}, 32'd0);
      chk("abort_x7_final", rf[7], 32'hAAAA1E1E);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
